// File: rtl/cpu_sequencer.sv
// Eight-phase instruction sequencer for the 8-bit RISC core: phase counter,
// halt/run state and the PC, memory, IR, accumulator and address-mux strobes.
module cpu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       run,
  output logic [2:0] phase,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       halt,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr
);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_t;

  phase_t phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   zero_q, zero_d;

  logic aluop;
  logic is_skz;
  logic is_jmp;
  logic is_sto;

  assign aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
  assign is_skz = (opcode == OP_SKZ);
  assign is_jmp = (opcode == OP_JMP);
  assign is_sto = (opcode == OP_STO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    zero_d   = zero_q;
    if (halted_q) begin
      if (run) begin
        halted_d = 1'b0;
        phase_d  = PH_INST_ADDR;
      end
    end else begin
      phase_d = phase_t'(phase_q + 3'd1);
      if (phase_q == PH_IDLE) begin
        zero_d = zero;
      end
      // HLT freezes the counter at OP_FETCH, which is where the increment lands anyway.
      if ((phase_q == PH_OP_ADDR) && (opcode == OP_HLT)) begin
        halted_d = 1'b1;
      end
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    halt   = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    if (!reset) begin
      if (halted_q) begin
        halt = 1'b1;
      end else begin
        case (phase_q)
          PH_INST_ADDR: begin
            sel = 1'b1;
          end
          PH_INST_FETCH: begin
            sel = 1'b1;
            rd  = 1'b1;
          end
          PH_INST_LOAD, PH_IDLE: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
          end
          PH_OP_ADDR: begin
            inc_pc = 1'b1;
          end
          PH_OP_FETCH: begin
            rd = aluop;
          end
          PH_ALU_OP: begin
            rd     = aluop;
            inc_pc = is_skz && zero_q;
            ld_pc  = is_jmp;
            data_e = is_sto;
          end
          PH_STORE: begin
            rd     = aluop;
            ld_ac  = aluop;
            ld_pc  = is_jmp;
            data_e = is_sto;
            wr     = is_sto;
          end
          default: begin
            sel = 1'b0;
          end
        endcase
      end
    end
  end

  assign phase = phase_q;

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Eight-phase instruction sequencer (control unit) for the 8-bit RISC core.
- Sits directly upstream of the program counter: generates its inc and load strobes, plus the memory, IR, accumulator and address-mux controls.
- Consumes the decoded opcode from the instruction register and the accumulator zero flag.
- Owns the halt/run state of the core.

Parameters:
- None. Opcode encodings come from the shared defines file and are fixed: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- opcode  input  3  IR[7:5], current instruction opcode
- zero  input  1  accumulator-is-zero flag
- run  input  1  level; restarts the core from halt
- phase  output  3  current phase, 0..7
- sel  output  1  address mux: 1 = PC, 0 = IR operand field
- rd  output  1  memory read enable
- ld_ir  output  1  instruction register load
- inc_pc  output  1  PC increment strobe
- ld_pc  output  1  PC load strobe (jump)
- halt  output  1  core halted
- data_e  output  1  accumulator drives data bus (store)
- ld_ac  output  1  accumulator load
- wr  output  1  memory write enable

Behaviour:
- State:
  - 3-bit phase counter.
  - halted flag.
  - zero_q: zero sampled at the end of phase 3.
- Reset (async, any time, including mid-instruction):
  - phase=0, halted=0, zero_q=0.
  - All strobes are forced to 0 while reset is asserted.
  - First fetch starts at phase 0 on the first clock edge after reset is released.
- Phase advance:
  - When not halted, phase increments by 1 every clock.
  - Wraps 7->0. No other jumps.
- Control outputs:
  - Combinational from registered phase, opcode and zero_q.
  - All are 0 when halted=1, except halt=1.
  - ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Per-phase outputs (anything not listed is 0):
  - 0 INST_ADDR: sel=1.
  - 1 INST_FETCH: sel=1, rd=1.
  - 2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - 3 IDLE: sel=1, rd=1, ld_ir=1. zero_q <= zero at the end of this phase.
  - 4 OP_ADDR: inc_pc=1. If opcode==HLT: halted <= 1 at the end of phase 4, and the phase counter freezes at 5.
  - 5 OP_FETCH: rd=ALUOP.
  - 6 ALU_OP: rd=ALUOP; inc_pc=(SKZ & zero_q); ld_pc=JMP; data_e=STO.
  - 7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; data_e=STO; wr=STO.
- PC strobe rules:
  - inc_pc and ld_pc are never both 1 in the same cycle.
  - Each fetched instruction produces exactly one inc_pc in phase 4. SKZ with zero_q=1 adds a second inc_pc in phase 6.
  - JMP holds ld_pc for two cycles (phases 6 and 7). The PC reloads the same target twice, which is harmless and intended.
- Halt:
  - While halted=1, the phase holds at 5 and halt=1.
  - When run=1 is sampled high while halted: halted <= 0 and phase <= 0 on the same edge. Execution resumes with a fetch at the already-incremented PC.
  - run is ignored when not halted.
  - reset has priority over run.
- Opcode stability: opcode may change only when ld_ir is active. Decode in phases 4..7 uses the IR value loaded in phase 3.

Test Plan:
- Reset release, opcode=ADD (2), zero=0, run=0:
  - phase sequence 0,1,...,7,0.
  - rd high in phases 1,2,3,5,6,7.
  - ld_ir high in phases 2,3.
  - inc_pc high only in phase 4.
  - ld_ac high only in phase 7.
- opcode=SKZ (1):
  - zero=1 at phase 3 -> inc_pc in phases 4 and 6.
  - Repeat with zero=1 set only at phase 5 -> inc_pc in phase 4 only, since zero_q was sampled 0.
- opcode=JMP (7) -> ld_pc high in phases 6 and 7; inc_pc only in phase 4; never both high together. opcode=STO (6) -> data_e in phases 6 and 7, wr in phase 7 only, rd=0 in phases 5..7.
- opcode=HLT (0):
  - After phase 4, halt=1, phase stays 5 for 20 cycles, all other strobes 0.
  - Pulse run=1 for one cycle -> next phase=0, halt=0, normal fetch resumes.
  - run=1 while running -> no effect on the sequence.
- Assert reset asynchronously mid-cycle during phase 6 of a JMP:
  - Outputs drop to 0 immediately, without waiting for a clock edge; phase=0.
  - After release, a clean fetch starts.
- Assert reset while halted -> halted clears, phase=0, and the sequence restarts without needing run.
